fm_sb_capture: RTL and testbench
================================

# fm_sb_capture

Write-side capture controller for one fast-monitoring spy buffer channel. It samples the 256-bit monitored stream `{fm_data, fm_vld}` and truncates each word to the channel's spy-buffer width. It drives the SB_MEM write port as a circular buffer under arm/trigger/freeze control, and on every freeze writes one metadata record into the SB_META port. One instance sits directly upstream of each mapped spy buffer (SB0..SB26), between the user-logic tap and the AXI-readable memories.

## Interface
Parameters:
- `DATA_W`, 96: SB_MEM data width; a multiple of 32 (axi_dw), at most 256 (mon_dw_max).
- `ADDR_W`, 10: SB_MEM address width.
- `META_ADDR_W`, 5: SB_META address width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `fm_data_i` in 256: monitored data.
- `fm_vld_i` in 1: monitored data valid.
- `pb_mode_i` in 2: mode; 00 off, 01 continuous, 10 triggered, 11 reserved (treated as 00).
- `arm_i` in 1: one-cycle pulse that starts capture.
- `trigger_i` in 1: one-cycle trigger pulse.
- `sw_freeze_i` in 1: software freeze pulse.
- `release_i` in 1: leave FROZEN.
- `post_trig_i` in ADDR_W: number of valid words written after the trigger word.
- `mem_we_o` out 1: SB_MEM write enable.
- `mem_addr_o` out ADDR_W: SB_MEM write address.
- `mem_data_o` out DATA_W: SB_MEM write data.
- `meta_we_o` out 1: SB_META write enable.
- `meta_addr_o` out META_ADDR_W: SB_META write address.
- `meta_data_o` out 64: metadata record.
- `state_o` out 2: IDLE=0, RUN=1, POST=2, FROZEN=3.
- `wptr_o` out ADDR_W: next write address.
- `wrapped_o` out 1: buffer has wrapped since the last arm.

## Operation
- States are IDLE, RUN, POST and FROZEN. Words are written only in RUN and POST, and only when `fm_vld_i`=1.
- Write data is `mem_data_o = fm_data_i[DATA_W-1:0]`. Upper bits are dropped.
- `wptr` increments by one on each write. It wraps from 2^ADDR_W-1 to 0; the wrap sets `wrapped_o`.
- The transition checks below are listed in priority order. Only the first that matches applies.
- Any state: if `pb_mode_i` is 00 or 11, go to IDLE.
- IDLE, RUN or POST: if `arm_i`, clear `wptr`, clear `wrapped_o`, clear the post counter, go to RUN. A valid word in the arm cycle is written at address 0.
- RUN or POST: if `sw_freeze_i`, go to FROZEN. A valid word in the same cycle is still written.
- RUN with mode 10: if `trigger_i`, the valid word in that cycle (if any) is written and is the trigger word.
  - Latch `trig_addr`, the address of the trigger word, or the current `wptr` if no valid word is present.
  - Latch the timestamp.
  - If `post_trig_i`=0, go to FROZEN; otherwise load the counter with `post_trig_i` and go to POST.
- RUN with mode 01: `trigger_i` is ignored.
- POST: each valid write decrements the counter. The write that takes it to 0 moves the state to FROZEN.
- POST: `trigger_i` is ignored.
- FROZEN: if `release_i`, go to IDLE. `arm_i` is ignored while FROZEN.
- Timestamp: a free-running 32-bit cycle counter, cleared at reset, wrapping silently. It is latched on trigger, or on `sw_freeze_i` if there was no trigger.
- Metadata record:
  - `meta_data_o[63:32]` = latched timestamp.
  - `[31]` = `wrapped_o`.
  - `[30]` = 1 if freeze was by software.
  - `[ADDR_W+15:16]` = `trig_addr`.
  - `[ADDR_W-1:0]` = final `wptr`.
  - All other bits 0.
- `meta_addr_o` increments after each metadata write and wraps modulo 2^META_ADDR_W. It is never cleared by arm.

## Timing
- Registered outputs: inputs sampled in cycle N appear on `mem_*` in cycle N+1, with latency 1 and no stalls.
- `state_o` shows the new state in N+1.
- `meta_we_o` is a one-cycle pulse, coincident with the first cycle that `state_o` = FROZEN.
- The final SB_MEM write and the metadata write may occur in the same cycle.
- Reset values: every output is 0, `state_o` is IDLE, and the timestamp and `meta_addr` are 0.
- Reset asserted mid-capture aborts immediately. No metadata is written.

## Configuration
- `FM_SB_CAPTURE_META_EN` defined: metadata path, timestamp counter and `meta_addr` counter are present as described.
- `FM_SB_CAPTURE_META_EN` undefined:
  - `meta_we_o`, `meta_addr_o` and `meta_data_o` are tied to 0, and the counters are removed.
  - The SB_MEM path and state machine are unchanged.

## Test plan
- Continuous wrap: mode 01, ADDR_W=4, arm, then 20 valid words d0..d19. Expect addresses 0..15,0..3, `wrapped_o`=1 from the 16th write, `wptr_o`=4, state RUN.
- Triggered, post_trig=3: arm at t=0, valid every cycle, trigger with word 5. Expect the trigger word at address 5 and writes at 6, 7, 8. Expect FROZEN and a `meta_we_o` pulse with the last write; record holds `trig_addr`=5, final `wptr`=9, bit30=0.
- post_trig=0 with trigger and `fm_vld_i` in one cycle: that word is written. FROZEN appears next cycle with meta written. No further writes while FROZEN even with `fm_vld_i`=1.
- sw_freeze beats trigger: both asserted in RUN. Expect FROZEN with bit30=1; a second freeze cycle later increments `meta_addr_o` to 2 after release and re-arm.
- Mode to 00 during POST, and mid-capture `rst_n` low: immediate IDLE, no meta write. All outputs 0 during reset.
- Macro undefined: repeat the triggered post_trig=3 scenario. Identical SB_MEM writes; `meta_*` stay 0.

Source files
------------

// File: rtl/fm_sb_capture.sv
// fm_sb_capture: write-side capture controller for one fast-monitoring spy
// buffer channel. Truncates the monitored stream to DATA_W, writes it into
// SB_MEM as a circular buffer under arm/trigger/freeze control, and emits one
// metadata record into SB_META on every freeze.
//
// Optional metadata path (timestamp, record, meta address counter) is built
// only when the macro FM_SB_CAPTURE_META_EN is defined; otherwise meta_* are
// tied to zero and the SB_MEM path is unchanged.
//
// Handshake: there is no backpressure. fm_vld_i qualifies fm_data_i in the
// cycle it is high. The SB_MEM and SB_META write ports always accept a write
// in the cycle their *_we_o is high. All outputs are registered: inputs
// sampled in cycle N show up on the outputs in cycle N+1.
module fm_sb_capture #(
  parameter int DATA_W      = 96,
  parameter int ADDR_W      = 10,
  parameter int META_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [255:0]           fm_data_i,
  input  logic                   fm_vld_i,
  input  logic [1:0]             pb_mode_i,
  input  logic                   arm_i,
  input  logic                   trigger_i,
  input  logic                   sw_freeze_i,
  input  logic                   release_i,
  input  logic [ADDR_W-1:0]      post_trig_i,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_data_o,
  output logic                   meta_we_o,
  output logic [META_ADDR_W-1:0] meta_addr_o,
  output logic [63:0]            meta_data_o,
  output logic [1:0]             state_o,
  output logic [ADDR_W-1:0]      wptr_o,
  output logic                   wrapped_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d, wr_addr;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic                wrapped_q, wrapped_d;
  logic                mode_on, active, do_arm, do_write, do_sw_freeze, trig_hit;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic                unused_fm_bits;

  // Bits above DATA_W are dropped by design.
  assign unused_fm_bits = ^fm_data_i;

  // Qualify this cycle's events and compute the write address and pointer update.
  always_comb begin
    mode_on      = (pb_mode_i == 2'b01) || (pb_mode_i == 2'b10);
    active       = (state_q == ST_RUN) || (state_q == ST_POST);
    do_arm       = mode_on && arm_i && (state_q != ST_FROZEN);
    do_write     = mode_on && fm_vld_i && (do_arm || active);
    do_sw_freeze = mode_on && !do_arm && active && sw_freeze_i;
    wr_addr      = do_arm ? '0 : wptr_q;
    wptr_d       = do_write ? (wr_addr + ADDR_W'(1)) : wr_addr;
    wrapped_d    = (do_arm ? 1'b0 : wrapped_q) | (do_write && (&wr_addr));
  end

  // Next-state logic; checks are ordered by priority.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    trig_hit   = 1'b0;
    if (!mode_on) begin
      state_d = ST_IDLE;
    end else if (do_arm) begin
      state_d    = ST_RUN;
      post_cnt_d = '0;
    end else if (do_sw_freeze) begin
      state_d = ST_FROZEN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if ((pb_mode_i == 2'b10) && trigger_i) begin
            trig_hit = 1'b1;
            if (post_trig_i == '0) begin
              state_d = ST_FROZEN;
            end else begin
              post_cnt_d = post_trig_i;
              state_d    = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (fm_vld_i) begin
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          if (release_i) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State, pointer and registered SB_MEM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      wrapped_q  <= 1'b0;
      post_cnt_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      wrapped_q  <= wrapped_d;
      post_cnt_q <= post_cnt_d;
      mem_we_q   <= do_write;
      if (do_write) begin
        mem_addr_q <= wr_addr;
        mem_data_q <= fm_data_i[DATA_W-1:0];
      end
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign state_o    = state_q;
  assign wptr_o     = wptr_q;
  assign wrapped_o  = wrapped_q;

`ifdef FM_SB_CAPTURE_META_EN
  logic [31:0]            ts_q, ts_lat_q, ts_lat_d;
  logic [ADDR_W-1:0]      trig_addr_q, trig_addr_d;
  logic                   freeze_ev;
  logic [63:0]            meta_rec;
  logic                   meta_we_q;
  logic [META_ADDR_W-1:0] meta_addr_q;
  logic [63:0]            meta_data_q;

  // Latch trigger context; the record uses post-write pointer/wrap values so
  // it describes the buffer exactly as it stands once frozen. trig_addr is
  // cleared on arm so a software-only freeze reports address 0.
  always_comb begin
    ts_lat_d    = ts_lat_q;
    trig_addr_d = trig_addr_q;
    if (do_arm) begin
      trig_addr_d = '0;
    end else if (trig_hit) begin
      trig_addr_d = wptr_q;
      ts_lat_d    = ts_q;
    end else if (do_sw_freeze && (state_q == ST_RUN)) begin
      ts_lat_d = ts_q;
    end
    freeze_ev                 = (state_d == ST_FROZEN) && (state_q != ST_FROZEN);
    meta_rec                  = '0;
    meta_rec[63:32]           = ts_lat_d;
    meta_rec[31]              = wrapped_d;
    meta_rec[30]              = do_sw_freeze;
    meta_rec[ADDR_W+15:16]    = trig_addr_d;
    meta_rec[ADDR_W-1:0]      = wptr_d;
  end

  // Free-running timestamp, trigger latches and the SB_META write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      ts_lat_q    <= '0;
      trig_addr_q <= '0;
      meta_we_q   <= 1'b0;
      meta_addr_q <= '0;
      meta_data_q <= '0;
    end else begin
      ts_q        <= ts_q + 32'd1;
      ts_lat_q    <= ts_lat_d;
      trig_addr_q <= trig_addr_d;
      meta_we_q   <= freeze_ev;
      meta_addr_q <= meta_addr_q + META_ADDR_W'(meta_we_q);
      if (freeze_ev) meta_data_q <= meta_rec;
    end
  end

  assign meta_we_o   = meta_we_q;
  assign meta_addr_o = meta_addr_q;
  assign meta_data_o = meta_data_q;
`else
  logic unused_trig_hit;

  assign unused_trig_hit = trig_hit;
  assign meta_we_o       = 1'b0;
  assign meta_addr_o     = '0;
  assign meta_data_o     = '0;
`endif

endmodule

// File: tb/tb_fm_sb_capture.sv
// Testbench for fm_sb_capture: directed scenarios, a behavioural model that
// predicts every output each cycle, and literal checks pinning key results.
module tb_fm_sb_capture;

  localparam int DATA_W      = 96;
  localparam int ADDR_W      = 4;
  localparam int META_ADDR_W = 5;
  localparam int DEPTH       = 16;
  localparam int EW          = ADDR_W + DATA_W;
`ifdef FM_SB_CAPTURE_META_EN
  localparam int META = 1;
`else
  localparam int META = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [255:0]           fm_data   = '0;
  logic                   fm_vld    = 1'b0;
  logic [1:0]             pb_mode   = 2'b00;
  logic                   arm       = 1'b0;
  logic                   trigger   = 1'b0;
  logic                   sw_freeze = 1'b0;
  logic                   rel       = 1'b0;
  logic [ADDR_W-1:0]      post_trig = '0;

  logic                   mem_we_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [DATA_W-1:0]      mem_data_o;
  logic                   meta_we_o;
  logic [META_ADDR_W-1:0] meta_addr_o;
  logic [63:0]            meta_data_o;
  logic [1:0]             state_o;
  logic [ADDR_W-1:0]      wptr_o;
  logic                   wrapped_o;

  fm_sb_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .META_ADDR_W(META_ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fm_data_i(fm_data), .fm_vld_i(fm_vld), .pb_mode_i(pb_mode),
    .arm_i(arm), .trigger_i(trigger), .sw_freeze_i(sw_freeze),
    .release_i(rel), .post_trig_i(post_trig),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .meta_we_o(meta_we_o), .meta_addr_o(meta_addr_o), .meta_data_o(meta_data_o),
    .state_o(state_o), .wptr_o(wptr_o), .wrapped_o(wrapped_o)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int   obs_addr[$];
  bit   obs_wrap[$];
  int   meta_cnt       = 0;
  logic [63:0] last_meta = '0;
  int   last_meta_addr = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int i);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = {8'(k), 8'hA5, 16'(i)};
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // States by number: 0 idle, 1 run, 2 post, 3 frozen.
  int          m_st = 0, m_wptr = 0, m_left = 0, m_trig_addr = 0, m_meta_addr = 0;
  bit          m_wrapped = 0, m_meta_we = 0;
  logic [31:0] m_ts = '0, m_ts_lat = '0;
  logic [63:0] m_meta_data = '0;

  initial forever begin : model
    bit on, wr, frz, frz_sw;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 0; m_wptr = 0; m_left = 0; m_trig_addr = 0; m_meta_addr = 0;
      m_wrapped = 0; m_meta_we = 0; m_ts = '0; m_ts_lat = '0; m_meta_data = '0;
      exp_q.delete();
    end else begin
      if (m_meta_we) m_meta_addr = (m_meta_addr + 1) % 32;
      m_meta_we = 0;
      on = (pb_mode == 2'b01) || (pb_mode == 2'b10);
      wr = 0; frz = 0; frz_sw = 0;
      if (!on) begin
        m_st = 0;
      end else if (arm && m_st != 3) begin
        m_wptr = 0; m_wrapped = 0; m_left = 0; m_trig_addr = 0;
        m_st = 1;
        wr = fm_vld;
      end else if (m_st == 1 || m_st == 2) begin
        wr = fm_vld;
        if (sw_freeze) begin
          frz = 1; frz_sw = 1;
          if (m_st == 1) m_ts_lat = m_ts;
        end else if (m_st == 1 && pb_mode == 2'b10 && trigger) begin
          m_trig_addr = m_wptr;
          m_ts_lat    = m_ts;
          if (post_trig == 0) frz = 1;
          else begin m_left = int'(post_trig); m_st = 2; end
        end else if (m_st == 2 && fm_vld) begin
          m_left--;
          if (m_left == 0) frz = 1;
        end
      end else if (m_st == 3 && rel) begin
        m_st = 0;
      end
      if (wr) begin
        exp_q.push_back({ADDR_W'(m_wptr), fm_data[DATA_W-1:0]});
        if (m_wptr == DEPTH - 1) m_wrapped = 1;
        m_wptr = (m_wptr + 1) % DEPTH;
      end
      if (frz) begin
        m_st = 3;
        m_meta_we = 1;
        m_meta_data = (64'(m_ts_lat) << 32) | (64'(m_wrapped) << 31) | (64'(frz_sw) << 30)
                    | (64'(m_trig_addr) << 16) | 64'(m_wptr);
      end
      m_ts = m_ts + 32'd1;
    end
  end

  // ---------------- compare process ----------------
  initial forever begin : compare
    logic [EW-1:0] e;
    @(negedge clk);
    if (!rst_n) begin
      check("reset_outputs", {mem_we_o, mem_addr_o, mem_data_o, meta_we_o, meta_addr_o,
                              meta_data_o, state_o, wptr_o, wrapped_o}, '0);
    end else begin
      check("state", state_o, m_st);
      check("wptr", wptr_o, m_wptr);
      check("wrapped", wrapped_o, m_wrapped);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mem_write", {mem_we_o, mem_addr_o, mem_data_o}, {1'b1, e});
      end else begin
        check("mem_we_idle", mem_we_o, 0);
      end
`ifdef FM_SB_CAPTURE_META_EN
      check("meta_we", meta_we_o, m_meta_we);
      check("meta_addr", meta_addr_o, m_meta_addr);
      if (m_meta_we) check("meta_data", meta_data_o, m_meta_data);
`else
      check("meta_tied", {meta_we_o, meta_addr_o, meta_data_o}, '0);
`endif
      if (mem_we_o) begin
        obs_addr.push_back(int'(mem_addr_o));
        obs_wrap.push_back(wrapped_o);
      end
      if (meta_we_o) begin
        meta_cnt++;
        last_meta      = meta_data_o;
        last_meta_addr = int'(meta_addr_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit vld, input int idx, input bit a = 0, input bit t = 0,
                      input bit f = 0, input bit r = 0);
    fm_vld = vld; fm_data = mk(idx);
    arm = a; trigger = t; sw_freeze = f; rel = r;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_wrap.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    idle(2);

    // Continuous wrap: 20 words into a 16-deep buffer.
    pb_mode = 2'b01;
    clear_obs();
    step(0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, i);
    idle(1);
    check("wrap_wptr", wptr_o, 4);
    check("wrap_flag", wrapped_o, 1);
    check("wrap_state", state_o, 1);
    check("wrap_count", obs_addr.size(), 20);
    check("wrap_addr15", obs_addr[15], 15);
    check("wrap_addr16", obs_addr[16], 0);
    check("wrap_addr19", obs_addr[19], 3);
    check("wrap_flag_w15", obs_wrap[14], 0);
    check("wrap_flag_w16", obs_wrap[15], 1);

    // Triggered, post_trig=3, trigger with word 5.
    pb_mode = 2'b10; post_trig = 4'd3;
    clear_obs();
    step(1, 0, 1);
    for (int i = 1; i < 5; i++) step(1, i);
    step(1, 5, 0, 1);
    for (int i = 6; i < 11; i++) step(1, i);
    check("trig_count", obs_addr.size(), 9);
    check("trig_addr5", obs_addr[5], 5);
    check("trig_addr8", obs_addr[8], 8);
    check("trig_state", state_o, 3);
    check("trig_meta_cnt", meta_cnt, META ? 1 : 0);
`ifdef FM_SB_CAPTURE_META_EN
    check("trig_rec_taddr", last_meta[19:16], 5);
    check("trig_rec_wptr", last_meta[3:0], 9);
    check("trig_rec_sw", last_meta[30], 0);
    check("trig_rec_wrap", last_meta[31], 0);
    check("trig_meta_addr", meta_addr_o, 1);
`endif
    step(1, 11, 1);
    idle(1);
    check("frozen_arm_ignored", state_o, 3);
    check("frozen_no_write", obs_addr.size(), 9);
    step(0, 0, 0, 0, 0, 1);
    check("release_idle", state_o, 0);

    // post_trig=0 with trigger and valid together.
    post_trig = 4'd0;
    clear_obs();
    step(0, 0, 1);
    step(1, 1); step(1, 2);
    step(1, 3, 0, 1);
    check("pt0_state", state_o, 3);
    step(1, 4); step(1, 5);
    idle(1);
    check("pt0_count", obs_addr.size(), 3);
    check("pt0_last_addr", obs_addr[2], 2);
`ifdef FM_SB_CAPTURE_META_EN
    check("pt0_rec_taddr", last_meta[19:16], 2);
    check("pt0_rec_wptr", last_meta[3:0], 3);
`endif
    step(0, 0, 0, 0, 0, 1);

    // sw_freeze beats trigger, then a second software freeze in mode 01.
    post_trig = 4'd3;
    clear_obs();
    step(0, 0, 1);
    step(1, 1); step(1, 2);
    step(1, 3, 0, 1, 1);
    idle(1);
    check("swf_state", state_o, 3);
    check("swf_count", obs_addr.size(), 3);
`ifdef FM_SB_CAPTURE_META_EN
    check("swf_rec_sw", last_meta[30], 1);
    check("swf_rec_wptr", last_meta[3:0], 3);
`endif
    step(0, 0, 0, 0, 0, 1);
    pb_mode = 2'b01;
    step(0, 0, 1);
    step(1, 7);
    step(0, 0, 0, 0, 1);
    idle(1);
    check("swf2_meta_addr", meta_addr_o, META ? 4 : 0);
    step(0, 0, 0, 0, 0, 1);

    // Software freeze while in POST keeps the trigger context.
    pb_mode = 2'b10; post_trig = 4'd5;
    step(0, 0, 1);
    step(1, 1); step(1, 2, 0, 1); step(1, 3);
    step(0, 0, 0, 0, 1);
    idle(1);
    check("postsw_state", state_o, 3);
`ifdef FM_SB_CAPTURE_META_EN
    check("postsw_rec_taddr", last_meta[19:16], 1);
    check("postsw_rec_sw", last_meta[30], 1);
`endif
    step(0, 0, 0, 0, 0, 1);

    // Mode to 00 during POST: immediate IDLE, no meta, no write.
    clear_obs();
    step(0, 0, 1);
    step(1, 1); step(1, 2, 0, 1); step(1, 3);
    pb_mode = 2'b00;
    step(1, 4);
    check("off_state", state_o, 0);
    pb_mode = 2'b10;
    step(1, 5);
    idle(1);
    check("off_stay_idle", state_o, 0);
    check("off_count", obs_addr.size(), 3);
    check("off_meta_cnt", meta_cnt, META ? 5 : 0);

    // Mid-capture reset aborts immediately.
    pb_mode = 2'b01;
    step(0, 0, 1);
    step(1, 1); step(1, 2); step(1, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", state_o, 0);
    check("rst_mid_wptr", wptr_o, 0);
    check("rst_mid_we", mem_we_o, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("rst_meta_addr", meta_addr_o, 0);
    check("rst_meta_cnt", meta_cnt, META ? 5 : 0);
    step(1, 9, 1);
    step(0, 0, 0, 0, 1);
    idle(1);
    check("rst_cap_state", state_o, 3);
    check("rst_cap_meta_cnt", meta_cnt, META ? 6 : 0);
`ifdef FM_SB_CAPTURE_META_EN
    check("rst_cap_meta_addr", last_meta_addr, 0);
    check("rst_cap_rec_wptr", last_meta[3:0], 1);
`endif
    step(0, 0, 0, 0, 0, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
